// File: rtl/seq_detect_param_if.sv
// Bundle of configuration, serial-input and status signals for the programmable pattern detector.
interface seq_detect_param_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
);
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               inp_valid;
  logic               inp_bit;
  logic               cnt_clr;
  logic               seq_seen;
  logic [CNT_W-1:0]   match_count;
  logic               inp_err;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, inp_valid, inp_bit, cnt_clr,
    input  seq_seen, match_count, inp_err
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, inp_valid, inp_bit, cnt_clr,
    output seq_seen, match_count, inp_err
  );
endinterface

// File: rtl/seq_detect_param.sv
// Run-time programmable serial bit-pattern detector with match pulse, saturating
// match counter and X/Z flagging. Comes out of reset as an overlapping 1011 detector.
module seq_detect_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input logic               clk,
  input logic               reset,
  seq_detect_param_if.slave bus
);

  localparam logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(4'b1011);
  localparam logic [LEN_W-1:0]   DEF_LEN = LEN_W'(4);
  localparam logic [LEN_W-1:0]   MAX_L   = LEN_W'(MAX_LEN);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [LEN_W-1:0] sat_fill(input logic [LEN_W-1:0] v);
    return (v >= MAX_L) ? MAX_L : v + LEN_W'(1);
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] v);
    return (v > MAX_L) ? MAX_L : v;
  endfunction

  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN; i++) m[i] = (i < int'(l));
    return m;
  endfunction

  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               seen_p1;
  logic               err_p1;

  logic               vld_p0;
  logic               bad_p0;
  logic               match_p0;
  logic [MAX_LEN-1:0] hist_nx;
  logic [LEN_W-1:0]   fill_nx;
  logic [LEN_W-1:0]   len_eff;

  // Stage p0: qualify the incoming bit and evaluate the match on the post-shift history
  always_comb begin
    bad_p0   = bus.inp_valid && $isunknown(bus.inp_bit);
    vld_p0   = bus.inp_valid && !bad_p0;
    hist_nx  = {hist_q[MAX_LEN-2:0], bus.inp_bit};
    fill_nx  = sat_fill(fill_q);
    len_eff  = clamp_len(len_q);
    match_p0 = vld_p0 && (len_eff >= LEN_W'(2)) && (fill_nx >= len_eff)
               && (((hist_nx ^ pat_q) & len_mask(len_eff)) == '0);
  end

  // Stage p1: state update and registered outputs; a config load always restarts the fill
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q   <= DEF_PAT;
      len_q   <= DEF_LEN;
      ovl_q   <= 1'b1;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      seen_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      if (bus.cfg_load) begin
        pat_q <= bus.cfg_pattern;
        len_q <= bus.cfg_len;
        ovl_q <= bus.cfg_overlap;
      end
      if (vld_p0) hist_q <= hist_nx;
      if (bus.cfg_load || bad_p0 || (match_p0 && !ovl_q)) fill_q <= '0;
      else if (vld_p0)                                     fill_q <= fill_nx;
      if (bus.cnt_clr)   cnt_q <= '0;
      else if (match_p0) cnt_q <= sat_inc(cnt_q);
      seen_p1 <= match_p0;
      err_p1  <= bad_p0;
    end
  end

  assign bus.seq_seen    = seen_p1;
  assign bus.inp_err     = err_p1;
  assign bus.match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: hand-derived vector table, a hand sequence with an X bit,
// and randomized traffic checked against a bit-history reference model.
module tb_seq_detect_param;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_detect_param_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus();

  seq_detect_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic       rst;
    logic       load;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       v;
    logic       b;
    logic       clr;
    logic       e_seen;
    logic       e_err;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t tab[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // Reference model: the raw list of accepted bits plus the number accepted since the last clear
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_bits[$];
  int         m_run;
  int         m_cnt;

  task automatic mdl_step(input vec_t t, output logic es, output logic ee, output logic [1:0] ec);
    int L;
    bit isx, acc, hit;
    if (t.rst === 1'b1) begin
      m_pat = 8'h0B; m_len = 4; m_ovl = 1'b1;
      m_bits.delete(); m_run = 0; m_cnt = 0;
      es = 1'b0; ee = 1'b0; ec = 2'd0;
      return;
    end
    L   = (m_len > MAX_LEN) ? MAX_LEN : m_len;
    isx = (t.v === 1'b1) && $isunknown(t.b);
    acc = (t.v === 1'b1) && !isx;
    hit = 1'b0;
    if (acc) begin
      m_bits.push_back(t.b);
      if (m_bits.size() > 16) void'(m_bits.pop_front());
      m_run++;
      if (L >= 2 && m_run >= L) begin
        hit = 1'b1;
        for (int k = 0; k < L; k++)
          if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) hit = 1'b0;
      end
      if (hit && !m_ovl) m_run = 0;
    end else if (isx) begin
      m_run = 0;
    end
    if (t.load === 1'b1) begin
      m_pat = t.pat; m_len = int'(t.len); m_ovl = t.ovl; m_run = 0;
    end
    if (t.clr === 1'b1)                      m_cnt = 0;
    else if (hit && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    es = hit; ee = isx; ec = 2'(m_cnt);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input vec_t t, input bit use_tab);
    logic es, ee;
    logic [1:0] ec;
    reset           = t.rst;
    bus.cfg_load    = t.load;
    bus.cfg_pattern = t.pat;
    bus.cfg_len     = t.len;
    bus.cfg_overlap = t.ovl;
    bus.inp_valid   = t.v;
    bus.inp_bit     = t.b;
    bus.cnt_clr     = t.clr;
    mdl_step(t, es, ee, ec);
    if (use_tab) begin es = t.e_seen; ee = t.e_err; ec = t.e_cnt; end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("seq_seen",    8'(bus.seq_seen),    8'(es));
    chk("inp_err",     8'(bus.inp_err),     8'(ee));
    chk("match_count", 8'(bus.match_count), 8'(ec));
  endtask

  task automatic add(input logic rst, input logic load, input logic [7:0] pat, input logic [3:0] len,
                     input logic ovl, input logic v, input logic b, input logic clr,
                     input logic e_seen, input logic e_err, input logic [1:0] e_cnt);
    vec_t t;
    t.rst = rst; t.load = load; t.pat = pat; t.len = len; t.ovl = ovl;
    t.v = v; t.b = b; t.clr = clr; t.e_seen = e_seen; t.e_err = e_err; t.e_cnt = e_cnt;
    tab.push_back(t);
  endtask

  task automatic addb(input logic b, input logic e_seen, input logic [1:0] e_cnt);
    add(1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1, b, 1'b0, e_seen, 1'b0, e_cnt);
  endtask

  task automatic addn(input logic [1:0] e_cnt);
    add(1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_cnt);
  endtask

  task automatic addr();
    add(1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic addl(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                      input logic clr, input logic [1:0] e_cnt);
    add(1'b0, 1'b1, pat, len, ovl, 1'b0, 1'b0, clr, 1'b0, 1'b0, e_cnt);
  endtask

  function automatic vec_t mkv(input logic rst, input logic v, input logic b);
    vec_t t;
    t.rst = rst; t.load = 1'b0; t.pat = 8'h00; t.len = 4'h0; t.ovl = 1'b0;
    t.v = v; t.b = b; t.clr = 1'b0; t.e_seen = 1'b0; t.e_err = 1'b0; t.e_cnt = 2'd0;
    return t;
  endfunction

  initial begin
    logic [7:0] p;
    vec_t       t;
    logic [3:0] xs_bits;

    reset = 1'b1;
    bus.cfg_load = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0;
    bus.inp_valid = 1'b0; bus.inp_bit = 1'b0; bus.cnt_clr = 1'b0;

    // Reset state, then default overlapping 1011 on 1,0,1,1,0,1,1
    addr(); addr();
    addb(1'b1,1'b0,2'd0); addb(1'b0,1'b0,2'd0); addb(1'b1,1'b0,2'd0); addb(1'b1,1'b1,2'd1);
    addb(1'b0,1'b0,2'd1); addb(1'b1,1'b0,2'd1); addb(1'b1,1'b1,2'd2);
    // Non-overlapping 1011 (counter cleared in the load cycle)
    addl(8'h0B, 4'd4, 1'b0, 1'b1, 2'd0);
    addb(1'b1,1'b0,2'd0); addb(1'b0,1'b0,2'd0); addb(1'b1,1'b0,2'd0); addb(1'b1,1'b1,2'd1);
    addb(1'b0,1'b0,2'd1); addb(1'b1,1'b0,2'd1); addb(1'b1,1'b0,2'd1);
    // Length 8, pattern A5, three bubbles between bits
    p = 8'hA5;
    addl(p, 4'd8, 1'b1, 1'b0, 2'd1);
    for (int i = 7; i >= 0; i--) begin
      addb(p[i], (i == 0), (i == 0) ? 2'd2 : 2'd1);
      if (i != 0) repeat (3) addn(2'd1);
    end
    addn(2'd2);
    // A bit accepted in the load cycle is judged by the old config; fill restarts after
    addr();
    addb(1'b1,1'b0,2'd0); addb(1'b0,1'b0,2'd0); addb(1'b1,1'b0,2'd0);
    add(1'b0, 1'b1, 8'h03, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1);
    addb(1'b1,1'b0,2'd1); addb(1'b1,1'b1,2'd2); addb(1'b1,1'b1,2'd3); addb(1'b0,1'b0,2'd3);
    // Reset mid-stream discards a valid bit and restores default config
    addr();
    addb(1'b1,1'b0,2'd0); addb(1'b0,1'b0,2'd0); addb(1'b1,1'b0,2'd0);
    add(1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    addb(1'b1,1'b0,2'd0); addb(1'b0,1'b0,2'd0); addb(1'b1,1'b0,2'd0); addb(1'b1,1'b1,2'd1);
    // Saturation at 3, then cnt_clr coincident with a match
    addr();
    addb(1'b1,1'b0,2'd0); addb(1'b0,1'b0,2'd0); addb(1'b1,1'b0,2'd0); addb(1'b1,1'b1,2'd1);
    addb(1'b0,1'b0,2'd1); addb(1'b1,1'b0,2'd1); addb(1'b1,1'b1,2'd2);
    addb(1'b0,1'b0,2'd2); addb(1'b1,1'b0,2'd2); addb(1'b1,1'b1,2'd3);
    addb(1'b0,1'b0,2'd3); addb(1'b1,1'b0,2'd3); addb(1'b1,1'b1,2'd3);
    addb(1'b0,1'b0,2'd3); addb(1'b1,1'b0,2'd3); addb(1'b1,1'b1,2'd3);
    addb(1'b0,1'b0,2'd3); addb(1'b1,1'b0,2'd3);
    add(1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    addb(1'b0,1'b0,2'd0); addb(1'b1,1'b0,2'd0); addb(1'b1,1'b1,2'd1);
    // Lengths 0 and 1 never match
    addl(8'h00, 4'd0, 1'b1, 1'b0, 2'd1);
    repeat (6) addb(1'b0, 1'b0, 2'd1);
    addl(8'h01, 4'd1, 1'b1, 1'b0, 2'd1);
    repeat (4) addb(1'b1, 1'b0, 2'd1);
    // Length 15 clamps to 8
    addl(p, 4'd15, 1'b1, 1'b0, 2'd1);
    for (int i = 7; i >= 0; i--) addb(p[i], (i == 0), (i == 0) ? 2'd2 : 2'd1);
    addn(2'd2);

    foreach (tab[i]) step(tab[i], 1'b1);

    // X/Z bit in the middle of a stream
    step(mkv(1'b1, 1'b0, 1'b0), 1'b0);
    xs_bits = 4'b1011;
    step(mkv(1'b0, 1'b1, 1'b1), 1'b0);
    step(mkv(1'b0, 1'b1, 1'b0), 1'b0);
    step(mkv(1'b0, 1'b1, 1'b1), 1'b0);
    step(mkv(1'b0, 1'b1, 1'bx), 1'b0);
    step(mkv(1'b0, 1'b1, 1'b1), 1'b0);
    step(mkv(1'b0, 1'b1, 1'b0), 1'b0);
    step(mkv(1'b0, 1'b1, 1'b1), 1'b0);
    step(mkv(1'b0, 1'b1, 1'b1), 1'b0);
    for (int i = 3; i >= 0; i--) step(mkv(1'b0, 1'b1, xs_bits[i]), 1'b0);

    // Randomized traffic against the reference model
    step(mkv(1'b1, 1'b0, 1'b0), 1'b0);
    for (int n = 0; n < 3000; n++) begin
      t = mkv(1'b0, 1'b0, 1'b0);
      t.rst  = ($urandom_range(0, 149) == 0);
      t.load = ($urandom_range(0, 29) == 0);
      t.pat  = 8'($urandom);
      t.len  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(2, 4));
      t.ovl  = 1'($urandom);
      t.v    = ($urandom_range(0, 3) != 0);
      t.b    = 1'($urandom);
      if ($urandom_range(0, 39) == 0) t.b = 1'bx;
      t.clr  = ($urandom_range(0, 49) == 0);
      step(t, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
